// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter sharing one 2R/1W register file among NREQ requesters,
// with a bounded lock for atomic sequences and a one-hot tagged response.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/ready/lock/we    per-requester handshake and access control
//   req_raddr1/raddr2/waddr    packed per-requester addresses (slice i = req i)
//   req_wdata                  packed per-requester write data
//   rsp_valid                  one-hot owner of rsp_rdata1/2 this cycle
//   rsp_rdata1/rsp_rdata2      read data passed through from the regfile
//   lock_timeout               high in the cycle a lock is forcibly released
//   rf_*                       regfile drive / return
module regfile_port_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NREQ       = 2,
   parameter int MAX_LOCK   = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NREQ-1:0]            req_valid,
   output logic [NREQ-1:0]            req_ready,
   input  logic [NREQ-1:0]            req_lock,
   input  logic [NREQ-1:0]            req_we,
   input  logic [NREQ*ADDR_WIDTH-1:0] req_raddr1,
   input  logic [NREQ*ADDR_WIDTH-1:0] req_raddr2,
   input  logic [NREQ*ADDR_WIDTH-1:0] req_waddr,
   input  logic [NREQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NREQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]      rsp_rdata1,
   output logic [DATA_WIDTH-1:0]      rsp_rdata2,
   output logic                       lock_timeout,
   output logic                       rf_reg_write,
   output logic [ADDR_WIDTH-1:0]      rf_read_addr1,
   output logic [ADDR_WIDTH-1:0]      rf_read_addr2,
   output logic [ADDR_WIDTH-1:0]      rf_write_addr,
   output logic [DATA_WIDTH-1:0]      rf_write_data,
   input  logic [DATA_WIDTH-1:0]      rf_read_data1,
   input  logic [DATA_WIDTH-1:0]      rf_read_data2
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] LOCKED = 1'b1;

   logic [0:0]      state;
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   owner;
   logic [CW-1:0]   lock_cnt;

   logic            gnt_any;
   logic [IW-1:0]   gnt_idx;
   logic [IW:0]     cand;
   logic            release_xfer;
   logic            cnt_expired;

   function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
      if (i == IW'(NREQ - 1)) return '0;
      else                    return i + 1'b1;
   endfunction

   // Locked: only the owner may win. Idle: first valid from rr_ptr upward.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      if (state == LOCKED) begin
         gnt_any = req_valid[owner];
         gnt_idx = owner;
      end else begin
         for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
            if (!gnt_any && req_valid[cand[IW-1:0]]) begin
               gnt_any = 1'b1;
               gnt_idx = cand[IW-1:0];
            end
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (gnt_any) req_ready[gnt_idx] = 1'b1;
   end

   always_comb begin
      rf_read_addr1 = '0;
      rf_read_addr2 = '0;
      rf_write_addr = '0;
      rf_write_data = '0;
      rf_reg_write  = 1'b0;
      if (gnt_any) begin
         rf_read_addr1 = req_raddr1[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
         rf_read_addr2 = req_raddr2[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
         rf_write_addr = req_waddr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
         rf_write_data = req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
         // x0 is hardwired; never let a write reach it
         rf_reg_write  = req_we[gnt_idx] & (|rf_write_addr);
      end
   end

   assign rsp_rdata1 = rf_read_data1;
   assign rsp_rdata2 = rf_read_data2;

   // An owner transfer with lock dropped wins over the timeout.
   assign release_xfer = (state == LOCKED) & gnt_any & ~req_lock[owner];
   assign cnt_expired  = (state == LOCKED) & (lock_cnt == CW'(MAX_LOCK - 1));
   assign lock_timeout = cnt_expired & ~release_xfer;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         owner     <= '0;
         lock_cnt  <= '0;
         rsp_valid <= '0;
      end else begin
         rsp_valid <= req_ready;
         case (state)
            IDLE: begin
               if (gnt_any) begin
                  rr_ptr <= next_idx(gnt_idx);
                  if (req_lock[gnt_idx]) begin
                     state    <= LOCKED;
                     owner    <= gnt_idx;
                     lock_cnt <= '0;
                  end
               end
            end
            default: begin
               lock_cnt <= lock_cnt + 1'b1;
               if (release_xfer || cnt_expired) begin
                  state    <= IDLE;
                  rr_ptr   <= next_idx(owner);
                  lock_cnt <= '0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a small sync-read regfile
// model attached to the rf_* ports.
module tb_regfile_port_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NR-1:0] req_valid, req_ready, req_lock, req_we, rsp_valid;
   logic [NR*AW-1:0] req_raddr1, req_raddr2, req_waddr;
   logic [NR*DW-1:0] req_wdata;
   logic [DW-1:0] rsp_rdata1, rsp_rdata2, rf_write_data;
   logic [DW-1:0] rf_read_data1, rf_read_data2;
   logic          lock_timeout, rf_reg_write;
   logic [AW-1:0] rf_read_addr1, rf_read_addr2, rf_write_addr;

   int n_chk  = 0;
   int n_fail = 0;

   logic [DW-1:0] mem [32];

   always #5 clk = ~clk;

   regfile_port_arbiter #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NREQ(NR), .MAX_LOCK(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_lock(req_lock), .req_we(req_we),
      .req_raddr1(req_raddr1), .req_raddr2(req_raddr2),
      .req_waddr(req_waddr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata1(rsp_rdata1),
      .rsp_rdata2(rsp_rdata2), .lock_timeout(lock_timeout),
      .rf_reg_write(rf_reg_write),
      .rf_read_addr1(rf_read_addr1), .rf_read_addr2(rf_read_addr2),
      .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
      .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2)
   );

   // Regfile: registered reads see the pre-write value; x0 reads as 0
   always @(posedge clk) begin
      if (rf_reg_write) mem[rf_write_addr] <= rf_write_data;
      rf_read_data1 <= (rf_read_addr1 == 0) ? '0 : mem[rf_read_addr1];
      rf_read_data2 <= (rf_read_addr2 == 0) ? '0 : mem[rf_read_addr2];
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs,
                      input logic [DW-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h1000 + i;
      mem[0] = '0;
      rf_read_data1 = '0;
      rf_read_data2 = '0;
      rst_n = 1'b0;
      req_valid = '0; req_lock = '0; req_we = '0;
      req_raddr1 = '0; req_raddr2 = '0; req_waddr = '0; req_wdata = '0;
      cyc(); cyc();
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_timeout", 32'(lock_timeout), 32'h0);
      chk("rst_rf_we", 32'(rf_reg_write), 32'h0);
      rst_n = 1'b1;
      cyc();

      // 1: alternating round-robin grants
      req_raddr1[0*AW +: AW] = 5'd1;
      req_raddr1[1*AW +: AW] = 5'd2;
      req_valid = 2'b11;
      #1;
      chk("rr_g0", 32'(req_ready), 32'h1);
      chk("rr_raddr0", 32'(rf_read_addr1), 32'h1);
      cyc();
      chk("rr_rsp0", 32'(rsp_valid), 32'h1);
      chk("rr_data0", rsp_rdata1, 32'h1001);
      chk("rr_g1", 32'(req_ready), 32'h2);
      chk("rr_raddr1", 32'(rf_read_addr1), 32'h2);
      cyc();
      chk("rr_rsp1", 32'(rsp_valid), 32'h2);
      chk("rr_data1", rsp_rdata1, 32'h1002);
      chk("rr_g2", 32'(req_ready), 32'h1);
      cyc();
      chk("rr_rsp2", 32'(rsp_valid), 32'h1);
      chk("rr_g3", 32'(req_ready), 32'h2);
      req_valid = 2'b00;
      #1;
      chk("idle_rf_addr", 32'(rf_read_addr1), 32'h0);
      cyc();
      chk("idle_rsp", 32'(rsp_valid), 32'h0);

      // 2: write x5 and read x5 in one access -> old value
      req_valid = 2'b01;
      req_we = 2'b01;
      req_waddr[0*AW +: AW] = 5'd5;
      req_wdata[0*DW +: DW] = 32'hDEADBEEF;
      req_raddr1[0*AW +: AW] = 5'd5;
      #1;
      chk("wr_ready", 32'(req_ready), 32'h1);
      chk("wr_we", 32'(rf_reg_write), 32'h1);
      chk("wr_addr", 32'(rf_write_addr), 32'h5);
      chk("wr_data", rf_write_data, 32'hDEADBEEF);
      cyc();
      chk("rbw_rsp", 32'(rsp_valid), 32'h1);
      chk("rbw_old", rsp_rdata1, 32'h1005);
      req_we = 2'b00;
      req_valid = 2'b10;
      req_raddr1[1*AW +: AW] = 5'd5;
      #1;
      chk("r1_ready", 32'(req_ready), 32'h2);
      cyc();
      chk("r1_rsp", 32'(rsp_valid), 32'h2);
      chk("r1_new", rsp_rdata1, 32'hDEADBEEF);
      req_valid = 2'b00;
      cyc();

      // 3: x0 write suppressed, x0 reads 0
      req_valid = 2'b01;
      req_we = 2'b01;
      req_waddr[0*AW +: AW] = 5'd0;
      req_wdata[0*DW +: DW] = 32'h1234;
      #1;
      chk("x0_ready", 32'(req_ready), 32'h1);
      chk("x0_we", 32'(rf_reg_write), 32'h0);
      cyc();
      req_we = 2'b00;
      req_raddr1[0*AW +: AW] = 5'd0;
      req_raddr2[0*AW +: AW] = 5'd5;
      cyc();
      req_valid = 2'b00;
      chk("x0_rd1", rsp_rdata1, 32'h0);
      chk("x0_rd2", rsp_rdata2, 32'hDEADBEEF);
      cyc();

      // 4: R1 holds a lock over 3 accesses while R0 waits
      req_valid = 2'b11;
      req_lock = 2'b10;
      #1;
      chk("lk_g1", 32'(req_ready), 32'h2);
      cyc();
      chk("lk_g2", 32'(req_ready), 32'h2);
      cyc();
      req_lock = 2'b00;
      #1;
      chk("lk_g3", 32'(req_ready), 32'h2);
      cyc();
      chk("lk_rsp3", 32'(rsp_valid), 32'h2);
      chk("lk_r0", 32'(req_ready), 32'h1);
      req_valid = 2'b00;
      cyc();

      // 5: forced release after MAX_LOCK cycles
      req_valid = 2'b01;
      req_lock = 2'b01;
      #1;
      chk("to_g0", 32'(req_ready), 32'h1);
      cyc();
      req_valid = 2'b00;
      req_lock = 2'b00;
      #1;
      chk("to_c0", 32'(lock_timeout), 32'h0);
      cyc();
      cyc();
      req_valid = 2'b10;
      #1;
      chk("to_c2", 32'(lock_timeout), 32'h0);
      chk("to_blk", 32'(req_ready), 32'h0);
      cyc();
      chk("to_pulse", 32'(lock_timeout), 32'h1);
      chk("to_blk2", 32'(req_ready), 32'h0);
      cyc();
      chk("to_end", 32'(lock_timeout), 32'h0);
      chk("to_r1", 32'(req_ready), 32'h2);
      req_valid = 2'b00;
      cyc();

      // 6: reset kills in-flight response and rr_ptr
      req_valid = 2'b01;
      cyc();
      req_valid = 2'b00;
      chk("rs_rsp", 32'(rsp_valid), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("rs_drop", 32'(rsp_valid), 32'h0);
      cyc();
      rst_n = 1'b1;
      req_valid = 2'b11;
      #1;
      chk("rs_tie", 32'(req_ready), 32'h1);
      req_valid = 2'b00;
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
